axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI4-Lite style memory responder that serves the LSU's load and store traffic.
- Accepts read-address, write-address and write-data requests; returns read data with rresp and write responses with bresp.
- Backed by an internal word-addressed SRAM array. Handles one transaction at a time with a programmable response latency.
- Sits between the core's memory arbiter and on-chip storage; also serves as the simulation memory model.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words (power of two)
- LATENCY, 1, cycles from request acceptance to response valid (1..15)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data (full word; the requester extracts byte/half)
- rresp  out  2  00 OKAY, 11 DECERR
- rvalid  out  1  read response valid
- rready  in  1  read response ready
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  00 OKAY, 11 DECERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP. Reset enters IDLE.
- Reset values: rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00, latency counter=0.
- Ready outputs:
  - arready=1 only in IDLE and not in reset.
  - awready=wready=1 only in IDLE, not in reset, and when no read is accepted that cycle.
- Read accept: IDLE and arvalid. Latch araddr, load the counter with LATENCY-1, go to RD_WAIT.
  - With LATENCY=1, go straight to RD_RESP on the next edge.
- Write accept: IDLE, awvalid, wvalid, and no arvalid. AW and W are accepted only together, in the same cycle.
  - A lone AW or a lone W is not accepted and waits.
  - Latch awaddr, wdata and wstrb; go to WR_WAIT under the same counter rule.
- Simultaneous arvalid and awvalid+wvalid: read wins; the write waits.
- RD_WAIT / WR_WAIT: decrement the counter each cycle; on 0, go to RD_RESP / WR_RESP.
- RD_RESP:
  - rvalid=1; rdata and rresp are stable until the rvalid&&rready handshake.
  - Handshake returns to IDLE; rvalid drops the next cycle.
  - There is no back-to-back accept in the handshake cycle; minimum read occupancy is LATENCY+1 cycles.
- WR_RESP:
  - The SRAM write commits on entry, on the cycle bvalid rises, for bytes with wstrb[i]=1.
  - bvalid is held until bready; then return to IDLE.
- Address decode: word index = (addr-ADDR_BASE)>>2. In range iff ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS.
  - Low two address bits are ignored.
  - Out of range: response 11 (DECERR), rdata=0, no SRAM write.
- wstrb=0000 gives an OKAY response with no SRAM change.
- Reset mid-transaction: the transaction is abandoned, valids drop the next cycle and the FSM returns to IDLE. SRAM contents are not cleared, and an uncommitted write is lost.

Optional Feature:
- SRAM_RAND_DELAY_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - On accept, the counter loads LATENCY-1 + lfsr[2:0], adding 0..7 extra wait cycles to stress requester stall paths.
- Not defined: fixed latency equal to LATENCY; no LFSR logic is present.

Decomposition:
- Shared package: AXI response codes (RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11) and the FSM state encoding.
- Sub-module sram_word_array (DEPTH_WORDS x 32) holds the storage:
  - one read port with combinational read;
  - one write port with per-byte enables, synchronous write.
- The LFSR stays inline.

Test Plan:
- Write 0xDEADBEEF to 0x8000_0010 with wstrb=1111, LATENCY=1 -> bvalid 2 cycles after accept, bresp=00. Read of 0x8000_0010 -> rdata=0xDEADBEEF, rresp=00.
- Write 0x000000AA to 0x8000_0010 with wstrb=0001 over 0xDEADBEEF -> read returns 0xDEADBEAA. wstrb=0000 write -> read unchanged, bresp=00.
- Read 0x7FFF_FFFC and 0x8000_1000 (DEPTH 1024) -> rresp=11, rdata=0. Write to 0x8000_1000 -> bresp=11 with no array change.
- arvalid together with awvalid+wvalid in the same cycle -> read accepted first (arready=1, awready=0). Write accepted the cycle after the read handshake completes.
- Hold rready=0 for 5 cycles in RD_RESP -> rvalid and rdata stay constant and arready stays 0. Repeat for bvalid/bready.
- Assert reset during WR_WAIT with LATENCY=4 -> bvalid=0 and the FSM is in IDLE after one cycle, the target word is unchanged, and arready=1 once reset deasserts.

Source files
------------

// File: rtl/axi_sram_responder_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// FSM state encoding, counter width and address-offset helper.
package axi_sram_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t RD_WAIT = 3'd1;
  localparam state_t RD_RESP = 3'd2;
  localparam state_t WR_WAIT = 3'd3;
  localparam state_t WR_RESP = 3'd4;

  // Wide enough for LATENCY-1 (max 14) plus up to 7 random extra cycles.
  localparam int unsigned CNT_W = 5;

  // Byte offset of an address from the array base; wraps for addresses
  // below the base so a single unsigned compare covers both bounds.
  function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/axi_sram_responder_sram_word_array.sv
// Word-addressed storage: combinational read port, synchronous write port
// with per-byte enables. Contents are not reset.
module sram_word_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rd_data = mem[rd_idx];

  // Byte-enabled write.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4-Lite style single-outstanding memory responder backed by
// sram_word_array. Optional macro SRAM_RAND_DELAY_EN adds 0..7 random
// wait cycles per transaction from an inline 16-bit LFSR.
module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_load;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       off_q;
  logic              addr_ok;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic              rd_accept;
  logic              wr_accept;

  assign arready   = (state == IDLE) && !reset;
  assign awready   = arready && !arvalid;
  assign wready    = awready;
  assign rd_accept = arready && arvalid;
  assign wr_accept = awready && awvalid && wvalid;

  assign off_q   = byte_offset(addr_q, ADDR_BASE);
  assign addr_ok = (off_q >> 2) < 32'(DEPTH_WORDS);
  assign idx     = off_q[IDX_W+1:2];

  // Commit happens on the edge that raises bvalid; reset in that cycle drops it.
  assign mem_we = (state == WR_WAIT) && (cnt == '0) && addr_ok && !reset;

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[2:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  sram_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clock   (clock),
    .rd_idx  (idx),
    .rd_data (mem_rdata),
    .wr_en   (mem_we),
    .wr_idx  (idx),
    .wr_data (wdata_q),
    .wr_strb (wstrb_q)
  );

  // Request capture; address register is shared by read and write paths.
  always_ff @(posedge clock) begin
    if (rd_accept) begin
      addr_q <= araddr;
    end else if (wr_accept) begin
      addr_q  <= awaddr;
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Transaction FSM with latency counter and registered responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rvalid <= 1'b0;
      bvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      bresp  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (rd_accept) begin
            state <= RD_WAIT;
            cnt   <= cnt_load;
          end else if (wr_accept) begin
            state <= WR_WAIT;
            cnt   <= cnt_load;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state  <= RD_RESP;
            rvalid <= 1'b1;
            rdata  <= addr_ok ? mem_rdata : '0;
            rresp  <= addr_ok ? RESP_OKAY : RESP_DECERR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESP: begin
          if (rready) begin
            state  <= IDLE;
            rvalid <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            state  <= WR_RESP;
            bvalid <= 1'b1;
            bresp  <= addr_ok ? RESP_OKAY : RESP_DECERR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_RESP: begin
          if (bready) begin
            state  <= IDLE;
            bvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Self-checking bench for axi_sram_responder: one LATENCY=1 instance for the
// functional scenarios and one LATENCY=4 instance for mid-transaction reset.
module tb_axi_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference memory contents for the LATENCY=1 instance.
  logic [31:0] mem_m [DEPTH];

  // LATENCY=1 instance signals
  logic        reset = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  // LATENCY=4 instance signals
  logic        reset4 = 1'b1;
  logic [31:0] araddr4 = '0, awaddr4 = '0, wdata4 = '0;
  logic        arvalid4 = 1'b0, rready4 = 1'b0, awvalid4 = 1'b0, wvalid4 = 1'b0, bready4 = 1'b0;
  logic [3:0]  wstrb4 = '0;
  logic        arready4, rvalid4, awready4, wready4, bvalid4;
  logic [31:0] rdata4;
  logic [1:0]  rresp4, bresp4;

  axi_sram_responder #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (1)
  ) u_dut (
    .clock (clk), .reset (reset),
    .araddr (araddr), .arvalid (arvalid), .arready (arready),
    .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready),
    .awaddr (awaddr), .awvalid (awvalid), .awready (awready),
    .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready),
    .bresp (bresp), .bvalid (bvalid), .bready (bready)
  );

  axi_sram_responder #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (4)
  ) u_dut4 (
    .clock (clk), .reset (reset4),
    .araddr (araddr4), .arvalid (arvalid4), .arready (arready4),
    .rdata (rdata4), .rresp (rresp4), .rvalid (rvalid4), .rready (rready4),
    .awaddr (awaddr4), .awvalid (awvalid4), .awready (awready4),
    .wdata (wdata4), .wstrb (wstrb4), .wvalid (wvalid4), .wready (wready4),
    .bresp (bresp4), .bvalid (bvalid4), .bready (bready4)
  );

  // Model helpers: address decode and byte-merge straight from the rules.
  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem_m[word_of(a)][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // Drives one write on the LATENCY=1 instance; returns response, cycles from
  // accept edge to bvalid, and whether bvalid/bresp held during the stall.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, output logic [1:0] r, output int lat,
                          output bit stable);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
    if (!(awready && wready)) begin
      checks++; failures++;
      $display("FAIL wr_accept_timeout addr=%h awready=%b want=1", a, awready);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    awaddr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    lat = 1;
    while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    if (!bvalid) begin
      checks++; failures++;
      $display("FAIL bvalid_timeout addr=%h bvalid=0 want=1", a);
    end
    r = bresp;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!bvalid || bresp !== r || arready || awready) stable = 1'b0;
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                         output logic [1:0] r, output int lat, output bit stable);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin
      checks++; failures++;
      $display("FAIL rd_accept_timeout addr=%h arready=0 want=1", a);
    end
    @(negedge clk);
    arvalid = 1'b0; araddr = $urandom;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    if (!rvalid) begin
      checks++; failures++;
      $display("FAIL rvalid_timeout addr=%h rvalid=0 want=1", a);
    end
    d = rdata; r = rresp;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rvalid || rdata !== d || rresp !== r || arready) stable = 1'b0;
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; reset4 = 1'b1;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rvalid, bvalid} !== 2'b00) begin
      failures++; $display("FAIL reset_valids got=%b want=00", {rvalid, bvalid});
    end
    checks++;
    if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      failures++; $display("FAIL reset_data rdata=%h rresp=%b bresp=%b want 0/00/00", rdata, rresp, bresp);
    end
    checks++;
    if ({arready, awready, wready} !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b want=000", {arready, awready, wready});
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    reset = 1'b0; reset4 = 1'b0;
    #1;
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      failures++; $display("FAIL post_reset_ready got=%b want=111", {arready, awready, wready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, r, lat, st);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (lat !== 2 || r !== 2'b00) begin
      failures++; $display("FAIL basic_write lat=%0d bresp=%b want lat=2 bresp=00", lat, r);
    end
    checks++;
    if (bvalid !== 1'b0) begin
      failures++; $display("FAIL basic_bvalid_drop got=%b want=0", bvalid);
    end
    do_read(32'h8000_0010, 0, d, r, lat, st);
    checks++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat !== 2) begin
      failures++; $display("FAIL basic_read rdata=%h rresp=%b lat=%0d want DEADBEEF/00/2", d, r, lat);
    end
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL basic_rvalid_drop got=%b want=0", rvalid);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    do_write(32'h8000_0010, 32'h0000_00AA, 4'b0001, 0, r, lat, st);
    model_write(32'h8000_0010, 32'h0000_00AA, 4'b0001);
    do_read(32'h8000_0010, 0, d, r, lat, st);
    checks++;
    if (d !== 32'hDEAD_BEAA || d !== mem_m[4]) begin
      failures++; $display("FAIL strobe_byte0 rdata=%h want=DEADBEAA", d);
    end
    do_write(32'h8000_0010, 32'h1111_2222, 4'b0000, 0, r, lat, st);
    checks++;
    if (r !== 2'b00) begin
      failures++; $display("FAIL strobe_none_bresp got=%b want=00", r);
    end
    do_read(32'h8000_0010, 0, d, r, lat, st);
    checks++;
    if (d !== 32'hDEAD_BEAA) begin
      failures++; $display("FAIL strobe_none_data rdata=%h want=DEADBEAA", d);
    end
  endtask

  task automatic test_decode();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    do_write(BASE, 32'h0BAD_F00D, 4'hF, 0, r, lat, st);
    model_write(BASE, 32'h0BAD_F00D, 4'hF);
    do_read(32'h7FFF_FFFC, 0, d, r, lat, st);
    checks++;
    if (r !== 2'b11 || d !== 32'h0) begin
      failures++; $display("FAIL decode_below rresp=%b rdata=%h want 11/0", r, d);
    end
    do_read(32'h8000_1000, 0, d, r, lat, st);
    checks++;
    if (r !== 2'b11 || d !== 32'h0) begin
      failures++; $display("FAIL decode_above rresp=%b rdata=%h want 11/0", r, d);
    end
    do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, r, lat, st);
    checks++;
    if (r !== 2'b11) begin
      failures++; $display("FAIL decode_write_bresp got=%b want=11", r);
    end
    do_read(BASE, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h0BAD_F00D || r !== 2'b00) begin
      failures++; $display("FAIL decode_no_alias rdata=%h rresp=%b want 0BADF00D/00", d, r);
    end
    do_write(32'h8000_0FFC, 32'hCAFE_0001, 4'hF, 0, r, lat, st);
    model_write(32'h8000_0FFC, 32'hCAFE_0001, 4'hF);
    do_read(32'h8000_0FFF, 0, d, r, lat, st);
    checks++;
    if (d !== 32'hCAFE_0001 || r !== 2'b00) begin
      failures++; $display("FAIL decode_last_word rdata=%h rresp=%b want CAFE0001/00", d, r);
    end
    do_read(32'h8000_0013, 0, d, r, lat, st);
    checks++;
    if (d !== mem_m[4] || r !== 2'b00) begin
      failures++; $display("FAIL decode_low_bits rdata=%h want=%h", d, mem_m[4]);
    end
  endtask

  task automatic test_read_priority();
    logic [1:0] r; logic [31:0] d; int lat, n; bit st, leaked;
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    awaddr = 32'h8000_0014; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; rready = 1'b0; bready = 1'b0;
    #1;
    checks++;
    if ({arready, awready, wready} !== 3'b100) begin
      failures++; $display("FAIL prio_ready got=%b want=100", {arready, awready, wready});
    end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0; leaked = 1'b0;
    while (!rvalid && n < 20) begin
      if (awready || wready) leaked = 1'b1;
      @(negedge clk); n++;
    end
    if (awready || wready) leaked = 1'b1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== mem_m[4] || leaked) begin
      failures++; $display("FAIL prio_read rvalid=%b rdata=%h aw_leak=%b want 1/%h/0", rvalid, rdata, leaked, mem_m[4]);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if ({rvalid, awready, wready} !== 3'b011) begin
      failures++; $display("FAIL prio_write_after got=%b want=011", {rvalid, awready, wready});
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (awready !== 1'b0) begin
      failures++; $display("FAIL prio_write_taken awready=%b want=0", awready);
    end
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    model_write(32'h8000_0014, 32'h1234_5678, 4'hF);
    do_read(32'h8000_0014, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h1234_5678 || r !== 2'b00) begin
      failures++; $display("FAIL prio_write_data rdata=%h rresp=%b want 12345678/00", d, r);
    end
  endtask

  task automatic test_hold();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    do_read(32'h8000_0010, 5, d, r, lat, st);
    checks++;
    if (!st || d !== mem_m[4]) begin
      failures++; $display("FAIL hold_read stable=%b rdata=%h want 1/%h", st, d, mem_m[4]);
    end
    do_write(32'h8000_0018, 32'h5A5A_A5A5, 4'hF, 5, r, lat, st);
    model_write(32'h8000_0018, 32'h5A5A_A5A5, 4'hF);
    checks++;
    if (!st || r !== 2'b00) begin
      failures++; $display("FAIL hold_write stable=%b bresp=%b want 1/00", st, r);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, got; logic [3:0] s; logic [1:0] r, er; int lat, idx; bit st, inr;
    for (int i = 16; i < 32; i++) begin
      d = $urandom;
      do_write(BASE + 32'(4 * i), d, 4'hF, 0, r, lat, st);
      model_write(BASE + 32'(4 * i), d, 4'hF);
    end
    for (int k = 0; k < 60; k++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      idx = 0;
      if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 256));
      else if (sel == 1) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 256)) + 32'($urandom_range(0, 3));
      else begin
        idx = int'($urandom_range(16, 31));
        a = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
      end
      inr = in_range(a);
      er  = inr ? 2'b00 : 2'b11;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        do_write(a, d, s, int'($urandom_range(0, 2)), r, lat, st);
        model_write(a, d, s);
        checks++;
        if (r !== er || lat !== 2 || !st) begin
          failures++; $display("FAIL rand_write k=%0d addr=%h bresp=%b lat=%0d st=%b want %b/2/1", k, a, r, lat, st, er);
        end
      end else begin
        do_read(a, int'($urandom_range(0, 3)), got, r, lat, st);
        checks++;
        if (r !== er || got !== (inr ? mem_m[word_of(a)] : 32'h0) || lat !== 2 || !st) begin
          failures++; $display("FAIL rand_read k=%0d addr=%h rdata=%h rresp=%b lat=%0d want %h/%b/2",
                               k, a, got, r, lat, inr ? mem_m[word_of(a)] : 32'h0, er);
        end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    int n, lat; bit seen;
    // Preload a word through the LATENCY=4 instance.
    @(negedge clk);
    awaddr4 = 32'h8000_0020; wdata4 = 32'h1122_3344; wstrb4 = 4'hF;
    awvalid4 = 1'b1; wvalid4 = 1'b1;
    @(negedge clk);
    awvalid4 = 1'b0; wvalid4 = 1'b0;
    lat = 1;
    while (!bvalid4 && lat < 50) begin @(negedge clk); lat++; end
    checks++;
    if (bvalid4 !== 1'b1 || lat !== 5 || bresp4 !== 2'b00) begin
      failures++; $display("FAIL lat4_write bvalid=%b lat=%0d bresp=%b want 1/5/00", bvalid4, lat, bresp4);
    end
    bready4 = 1'b1;
    @(negedge clk);
    bready4 = 1'b0;
    // Overwrite attempt abandoned by reset while waiting.
    awaddr4 = 32'h8000_0020; wdata4 = 32'hFFFF_FFFF; wstrb4 = 4'hF;
    awvalid4 = 1'b1; wvalid4 = 1'b1;
    @(negedge clk);
    awvalid4 = 1'b0; wvalid4 = 1'b0;
    @(negedge clk);
    reset4 = 1'b1;
    @(negedge clk);
    checks++;
    if ({bvalid4, arready4} !== 2'b00) begin
      failures++; $display("FAIL midreset_in_reset bvalid=%b arready=%b want 0/0", bvalid4, arready4);
    end
    reset4 = 1'b0;
    #1;
    checks++;
    if (arready4 !== 1'b1) begin
      failures++; $display("FAIL midreset_idle arready=%b want=1", arready4);
    end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (bvalid4) seen = 1'b1; end
    checks++;
    if (seen) begin
      failures++; $display("FAIL midreset_no_bvalid got=1 want=0");
    end
    araddr4 = 32'h8000_0020; arvalid4 = 1'b1;
    @(negedge clk);
    arvalid4 = 1'b0;
    n = 0;
    while (!rvalid4 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (rvalid4 !== 1'b1 || rdata4 !== 32'h1122_3344 || rresp4 !== 2'b00) begin
      failures++; $display("FAIL midreset_word rvalid=%b rdata=%h rresp=%b want 1/11223344/00", rvalid4, rdata4, rresp4);
    end
    rready4 = 1'b1;
    @(negedge clk);
    rready4 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_decode();
    test_read_priority();
    test_hold();
    test_random();
    test_reset_midwrite();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
